// File: rtl/proc_link_tx.sv
// proc_link_tx: transmit end of the processor's outbound link.
// Words strobed on snd are queued in a small FIFO, then each word is sent on tx as four
// UART 8N1 frames, least-significant byte first. The line is driven from a register so it
// never glitches; it follows the FSM by one clock.
module proc_link_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd,
    input  logic [31:0] interface_data,
    input  logic        clr_overflow,
    output logic        tx,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic        tx_done
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [TW-1:0] TIMER_MAX  = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    // FIFO storage and bookkeeping
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    // Serializer state
    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [1:0]    byte_idx_q;
    logic [31:0]   shift_q;

    // Registered line outputs
    logic          tx_q;
    logic          tx_d;
    logic          word_end_q;
    logic          word_end_d;
    logic          tx_done_q;

    logic          push;
    logic          pop;
    logic          bit_tick;
    logic [7:0]    cur_byte;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never frees a slot for snd.
    assign fifo_full = (count_q == COUNT_FULL);
    assign push      = snd && !fifo_full;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign bit_tick  = (timer_q == TIMER_MAX);
    assign cur_byte  = shift_q[7:0];

    assign tx        = tx_q;
    assign tx_busy   = (count_q != '0) || (state_q != StIdle);
    assign overflow  = overflow_q;
    assign tx_done   = tx_done_q;

    // FIFO data array; contents are don't-care while the entry is unoccupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= interface_data;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (snd && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_tick && (bit_idx_q == 3'd7)) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    state_d = (byte_idx_q == 2'd3) ? StIdle : StStart;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bit timer, bit/byte indices and the word shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
        end else begin
            if (state_q == StIdle || bit_tick) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q    <= mem[rd_ptr_q];
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                    end
                end
                StStart: begin
                    if (bit_tick) begin
                        bit_idx_q <= '0;
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                StStop: begin
                    // Next byte moves into the low lane; the last byte leaves the word as is.
                    if (bit_tick && (byte_idx_q != 2'd3)) begin
                        shift_q    <= {8'h00, shift_q[31:8]};
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM output logic: line level for the current bit and end-of-word detect.
    always_comb begin
        tx_d       = 1'b1;
        word_end_d = 1'b0;
        case (state_q)
            StIdle:  tx_d = 1'b1;
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_idx_q];
            StStop: begin
                tx_d       = 1'b1;
                word_end_d = bit_tick && (byte_idx_q == 2'd3);
            end
            default: tx_d = 1'b1;
        endcase
    end

    // Output registers; tx_done is delayed a further cycle so it lines up with the end of
    // the last stop bit as seen on tx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q       <= 1'b1;
            word_end_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_q       <= tx_d;
            word_end_q <= word_end_d;
            tx_done_q  <= word_end_q;
        end
    end

endmodule
